// File: rtl/pov_pkg.sv
// Shared types and constants for the POV LED sequencer.
package pov_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StRun,
    StStall
  } pov_state_e;

  localparam int unsigned MIN_PERIOD_MULT = 2;
  localparam logic [1:0]  PIO_DATA_ADDR   = 2'd0;

endpackage

// File: rtl/pov_led_sequencer_if.sv
// Avalon-MM write-only link from the sequencer to the LED PIO slave.
interface pov_led_sequencer_if;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  modport master (output m_address, output m_chipselect, output m_write_n, output m_writedata);
  modport slave  (input m_address, input m_chipselect, input m_write_n, input m_writedata);
endinterface

// File: rtl/pov_period_meter.sv
// Hall input synchronizer, rising-edge tick and saturating revolution-period counter.
module pov_period_meter #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                hall_in,
  output logic                tick,
  output logic [PERIOD_W-1:0] period,
  output logic                sat
);

  logic [1:0]          r_sync;
  logic                r_prev;
  logic                r_tick;
  logic [PERIOD_W-1:0] r_count;

  // Count restarts at 1 on a tick so the value seen at the next tick is the full period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_tick  <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync <= {r_sync[0], hall_in};
      r_prev <= r_sync[1];
      r_tick <= r_sync[1] & ~r_prev;
      if (clr) begin
        r_count <= '0;
      end else if (r_tick) begin
        r_count <= PERIOD_W'(1);
      end else if (!sat) begin
        r_count <= r_count + PERIOD_W'(1);
      end
    end
  end

  assign tick   = r_tick;
  assign period = r_count;
  assign sat    = &r_count;

endmodule

// File: rtl/pov_led_sequencer.sv
// POV LED column sequencer: FSM, column timer, pattern RAM and Avalon-MM PIO writer.
// Build option POV_STALL_BLANK_EN: blank the LEDs with a write of 0 when leaving RUN.
module pov_led_sequencer
  import pov_pkg::*;
#(
  parameter int unsigned NUM_COLS = 64,
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        hall_in,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_COLS)-1:0] cfg_addr,
  input  logic [DATA_W-1:0]           cfg_wdata,
  pov_led_sequencer_if.master         m_bus,
  output logic                        locked,
  output logic [$clog2(NUM_COLS)-1:0] col_idx,
  output logic                        overrun
);

  localparam int unsigned ColW = $clog2(NUM_COLS);

  logic [DATA_W-1:0]   r_ram [NUM_COLS];
  pov_state_e          r_state;
  logic [PERIOD_W-1:0] r_col_period;
  logic [PERIOD_W-1:0] r_col_timer;
  logic [ColW-1:0]     r_col_idx;
  logic                r_locked;
  logic                r_overrun;
  logic                r_armed;
  logic                r_cs;
  logic [31:0]         r_wdata;

  logic                w_tick;
  logic                w_sat;
  logic [PERIOD_W-1:0] w_period;
  logic                w_short;
  logic                w_last_col;
  logic                w_timer_end;
  logic                w_adv;
  logic                w_start_tick;
  logic                w_col_start;
  logic [ColW-1:0]     w_rd_addr;
  logic [31:0]         w_rd_ext;

  pov_period_meter #(
    .PERIOD_W (PERIOD_W)
  ) u_meter (
    .clk     (clk),
    .reset   (reset),
    .clr     (r_state == StIdle),
    .hall_in (hall_in),
    .tick    (w_tick),
    .period  (w_period),
    .sat     (w_sat)
  );

  // Unreset RAM; a read in the same cycle as a write to that address sees the old word.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      r_ram[cfg_addr] <= cfg_wdata;
    end
  end

  assign w_short      = w_period < PERIOD_W'(MIN_PERIOD_MULT * NUM_COLS);
  assign w_last_col   = r_col_idx == ColW'(NUM_COLS - 1);
  assign w_timer_end  = r_col_timer == r_col_period - PERIOD_W'(1);
  assign w_adv        = (r_state == StRun) && !w_tick && w_timer_end && !w_last_col;
  assign w_start_tick = w_tick && ((r_state == StRun) ||
                                   ((r_state == StMeasure) && r_armed && !w_short));
  assign w_col_start  = w_start_tick || w_adv;
  assign w_rd_addr    = w_start_tick ? '0 : r_col_idx + ColW'(1);
  assign w_rd_ext     = 32'(r_ram[w_rd_addr]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_col_period <= '0;
      r_col_timer  <= '0;
      r_col_idx    <= '0;
      r_locked     <= 1'b0;
      r_overrun    <= 1'b0;
      r_armed      <= 1'b0;
      r_cs         <= 1'b0;
      r_wdata      <= '0;
    end else begin
      r_cs    <= 1'b0;
      r_wdata <= '0;
      if (!enable) begin
        r_state  <= StIdle;
        r_locked <= 1'b0;
        r_armed  <= 1'b0;
`ifdef POV_STALL_BLANK_EN
        if (r_state == StRun) begin
          r_cs <= 1'b1;
        end
`endif
      end else begin
        if (w_col_start) begin
          r_cs        <= 1'b1;
          r_wdata     <= w_rd_ext;
          r_col_timer <= '0;
        end else if (!w_timer_end) begin
          r_col_timer <= r_col_timer + PERIOD_W'(1);
        end
        if (w_adv) begin
          r_col_idx <= r_col_idx + ColW'(1);
        end
        unique case (r_state)
          StIdle: begin
            r_state <= StMeasure;
            r_armed <= 1'b0;
          end
          StMeasure: begin
            if (w_tick) begin
              if (!r_armed) begin
                r_armed <= 1'b1;
              end else if (w_short) begin
                r_overrun <= 1'b1;
              end else begin
                r_col_period <= w_period >> ColW;
                r_col_idx    <= '0;
                r_state      <= StRun;
                r_locked     <= 1'b1;
              end
            end else if (w_sat) begin
              r_state <= StStall;
            end
          end
          StRun: begin
            if (w_tick) begin
              // A tick always restarts the revolution, even when its period is rejected.
              r_col_idx <= '0;
              if (w_short) begin
                r_overrun <= 1'b1;
              end else begin
                r_col_period <= w_period >> ColW;
              end
            end else if (w_sat) begin
              r_state  <= StStall;
              r_locked <= 1'b0;
`ifdef POV_STALL_BLANK_EN
              r_cs    <= 1'b1;
              r_wdata <= '0;
`endif
            end
          end
          StStall: begin
            if (w_tick) begin
              r_state <= StMeasure;
              r_armed <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  // Reset kills an in-flight strobe combinationally, before the registers clear.
  assign m_bus.m_address    = PIO_DATA_ADDR;
  assign m_bus.m_chipselect = r_cs & ~reset;
  assign m_bus.m_write_n    = ~(r_cs & ~reset);
  assign m_bus.m_writedata  = reset ? '0 : r_wdata;

  assign locked  = r_locked;
  assign col_idx = r_col_idx;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_pov_led_sequencer.sv
// Scoreboard bench for pov_led_sequencer: expected PIO writes are queued per revolution.
module tb_pov_led_sequencer;
  import pov_pkg::*;

  localparam int unsigned NumCols = 64;
  localparam int unsigned PeriodW = 14;
  localparam int unsigned DataW   = 32;
  localparam int unsigned SatCnt  = (1 << PeriodW) - 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             hall_in;
  logic             cfg_we;
  logic [5:0]       cfg_addr;
  logic [DataW-1:0] cfg_wdata;
  logic             locked;
  logic [5:0]       col_idx;
  logic             overrun;

  pov_led_sequencer_if bus ();

  pov_led_sequencer #(
    .NUM_COLS (NumCols),
    .PERIOD_W (PeriodW),
    .DATA_W   (DataW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .hall_in   (hall_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .m_bus     (bus),
    .locked    (locked),
    .col_idx   (col_idx),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  wr_t         sb[$];
  logic [31:0] pat [NumCols];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.m_chipselect === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("wr_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check_eq("wr_cyc", 32'(cyc), 32'(e.cyc));
        check_eq("wr_data", bus.m_writedata, e.data);
        check_eq("wr_n", 32'(bus.m_write_n), 32'd0);
        check_eq("wr_addr", 32'(bus.m_address), 32'd0);
      end
    end
  end

  task automatic goto(input int t);
    if (cyc > t) check_eq("sched_late", 32'(cyc), 32'(t));
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int t);
    goto(t);
    @(negedge clk);
  endtask

  // Hall edge driven in cycle t gives a tick in t+3 and the column-0 write in t+4.
  task automatic pulse(input int t);
    goto(t);
    hall_in = 1'b1;
    goto(t + 4);
    hall_in = 1'b0;
  endtask

  task automatic push_rev(input int t, input int n, input int per);
    for (int k = 0; k < n; k++) sb.push_back('{cyc: t + 4 + per * k, data: pat[k]});
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_cs"}, 32'(bus.m_chipselect), 32'd0);
    check_eq({tag, "_wn"}, 32'(bus.m_write_n), 32'd1);
    check_eq({tag, "_wdata"}, bus.m_writedata, 32'd0);
    check_eq({tag, "_locked"}, 32'(locked), 32'd0);
    check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
    check_eq({tag, "_colidx"}, 32'(col_idx), 32'd0);
    check_eq({tag, "_state"}, 32'(dut.r_state), 32'(StIdle));
  endtask

  initial begin
    #(10 * 120000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, c1, c2, c3, c4, c5, c6, s, c7, c8;
    reset = 1'b1; enable = 1'b0; hall_in = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    for (int i = 0; i < NumCols; i++) pat[i] = $urandom;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < NumCols; i++) begin
      cfg_we = 1'b1; cfg_addr = 6'(i); cfg_wdata = pat[i];
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
    enable = 1'b1;

    // Lock-in at 6400 cycles per revolution.
    b = cyc + 10;
    pulse(b);
    at_neg(b + 10);
    check_eq("measure_locked", 32'(locked), 32'd0);
    c1 = b + 6400;
    push_rev(c1, 64, 100);
    pulse(c1);
    at_neg(c1 + 4);
    check_eq("lock_locked", 32'(locked), 32'd1);
    check_eq("lock_colper", 32'(dut.r_col_period), 32'd100);

    // Overwrite column 5 in the very cycle it is read: old word now, new word next revolution.
    goto(c1 + 503);
    cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = 32'hA5;
    goto(c1 + 504);
    cfg_we = 1'b0;
    pat[5] = 32'hA5;

    c2 = c1 + 6400;
    push_rev(c2, 64, 100);
    pulse(c2);
    at_neg(c2 + 504);
    check_eq("col5_data", bus.m_writedata, 32'hA5);

    // Short revolution coincides with the column-1 advance; the tick wins.
    c3 = c2 + 6400;
    push_rev(c3, 1, 100);
    pulse(c3);
    at_neg(c3 + 50);
    check_eq("pre_overrun", 32'(overrun), 32'd0);
    c4 = c3 + 100;
    push_rev(c4, 64, 100);
    pulse(c4);
    at_neg(c4 + 4);
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    check_eq("ovr_locked", 32'(locked), 32'd1);
    check_eq("ovr_colidx", 32'(col_idx), 32'd0);
    check_eq("ovr_colper", 32'(dut.r_col_period), 32'd100);

    // Longer revolution: last column holds, no wrap writes.
    c5 = c4 + 7000;
    at_neg(c5 - 1);
    check_eq("hold63_a", 32'(col_idx), 32'd63);
    push_rev(c5, 64, 109);
    pulse(c5);
    at_neg(c5 + 4);
    check_eq("p7000_colper", 32'(dut.r_col_period), 32'd109);
    c6 = c5 + 7000;
    at_neg(c6 - 1);
    check_eq("hold63_b", 32'(col_idx), 32'd63);
    push_rev(c6, 64, 109);
    pulse(c6);

    // Ticks stop: counter saturates, FSM stalls.
    s = c6 + 3 + int'(SatCnt);
`ifdef POV_STALL_BLANK_EN
    sb.push_back('{cyc: s + 1, data: 32'h0});
`endif
    at_neg(s);
    check_eq("sat_count", 32'(dut.u_meter.r_count), 32'(SatCnt));
    check_eq("sat_pre_locked", 32'(locked), 32'd1);
    at_neg(s + 1);
    check_eq("stall_locked", 32'(locked), 32'd0);
    check_eq("stall_state", 32'(dut.r_state), 32'(StStall));
    at_neg(s + 30);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    enable = 1'b0;
    at_neg(s + 32);
    check_eq("dis_state", 32'(dut.r_state), 32'(StIdle));

    // Relock, then reset lands on the column-0 strobe.
    goto(s + 40);
    enable = 1'b1;
    c7 = s + 50;
    pulse(c7);
    c8 = c7 + 6400;
    pulse(c8);
    check_eq("mid_wr_cs", 32'(bus.m_chipselect), 32'd1);
    reset = 1'b1;
    enable = 1'b0;
    #1;
    check_eq("rst_same_cyc_cs", 32'(bus.m_chipselect), 32'd0);
    at_neg(c8 + 5);
    check_reset_state("midrst");
    goto(c8 + 6);
    reset = 1'b0;
    at_neg(c8 + 20);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
